// File: rtl/cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cu_pkg                                                       |
// | Description : Shared types and constants for the CU issue sequencer:       |
// |               instruction classes, sequencer states, forwarding codes and  |
// |               the PC step size.                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package cu_pkg;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        BRANCH = 3'd3,
        JAL    = 3'd4,
        JALR   = 3'd5,
        SYSTEM = 3'd6
    } instr_class_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        JSTALL = 3'd4,
        HALT   = 3'd5
    } seq_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_RS1  = 2'b01;
    localparam logic [1:0] FWD_RS2  = 2'b10;
    localparam logic [1:0] FWD_BOTH = 2'b11;

    localparam int unsigned PC_STEP = 4;

    // Classes that produce a register result (JAL/JALR write the link address).
    function automatic logic class_writes_rd(input instr_class_e cls);
        return (cls == ALU) || (cls == LOAD) || (cls == JAL) || (cls == JALR);
    endfunction

endpackage : cu_pkg
`default_nettype wire

// File: rtl/cu_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cu_hazard_detect                                             |
// | Description : Combinational RAW check of the incoming source registers     |
// |               against the destination of the last retired instruction.    |
// | Ports       : rs1, rs2   in  5  source register indices                     |
// |               last_rd    in  5  destination of last retirement (0 = none)  |
// |               fwd_sel    out 2  FWD_NONE / FWD_RS1 / FWD_RS2 / FWD_BOTH     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cu_hazard_detect
    import cu_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] last_rd,
    output logic [1:0] fwd_sel
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired zero, so it never needs forwarding.
    assign w_rs1_hit = (rs1 == last_rd) && (last_rd != 5'd0);
    assign w_rs2_hit = (rs2 == last_rd) && (last_rd != 5'd0);

    always_comb begin
        fwd_sel = FWD_NONE;
        case ({w_rs2_hit, w_rs1_hit})
            2'b01:   fwd_sel = FWD_RS1;
            2'b10:   fwd_sel = FWD_RS2;
            2'b11:   fwd_sel = FWD_BOTH;
            default: fwd_sel = FWD_NONE;
        endcase
    end

endmodule : cu_hazard_detect
`default_nettype wire

// File: rtl/cu_issue_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cu_issue_sequencer                                           |
// | Description : Sequences decoded instructions from the IDU through the      |
// |               shared ALU one at a time: ISSUE drives the opcode, EXEC      |
// |               pulses alu_start and waits for alu_done, then WB writes the  |
// |               result or JSTALL issues the PC redirect (plus link write).  |
// |               Halts on SYSTEM, ALU fault, ALU timeout or PC overrun.       |
// | Ports       : soc_clk, reset (sync, active-high)                            |
// |               IDU_ready/cu_accept  instruction handshake                    |
// |               instr_class, alu_op_in, rd, rs1, rs2  decoded instruction    |
// |               alu_op_out, alu_start / alu_done, alu_result, branch_taken,  |
// |               alu_err              ALU interface                            |
// |               wb_en, wb_addr, wb_data  register write port                  |
// |               fwd_sel              RAW forwarding flags                     |
// |               pc_redirect, pc_target, cu_pc  program counter                |
// |               halt, err            sticky status                            |
// |               perf_retired, perf_stall  performance counters               |
// | Config      : CU_SEQ_PERF_EN enables the performance counters; otherwise   |
// |               the perf ports read as zero and no counter flops exist.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cu_issue_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ALU_TIMEOUT = 8,
    parameter int unsigned PC_LIMIT    = 512
) (
    input  logic              soc_clk,
    input  logic              reset,
    input  logic              IDU_ready,
    output logic              cu_accept,
    input  instr_class_e      instr_class,
    input  logic [4:0]        alu_op_in,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic [4:0]        alu_op_out,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              branch_taken,
    input  logic              alu_err,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic [1:0]        fwd_sel,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   pc_target,
    output logic [XLEN-1:0]   cu_pc,
    output logic              halt,
    output logic              err,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_stall
);

    localparam int unsigned           c_cnt_w    = $clog2(ALU_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]    c_tmo_max  = c_cnt_w'(ALU_TIMEOUT);
    localparam logic [XLEN-1:0]       c_pc_limit = XLEN'(PC_LIMIT);
    localparam logic [XLEN-1:0]       c_pc_step  = XLEN'(PC_STEP);

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    instr_class_e        r_cls;
    logic [4:0]          r_op;
    logic [4:0]          r_rd;
    logic [4:0]          r_last_rd;
    logic [1:0]          r_fwd_sel;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     r_pc;
    logic [c_cnt_w-1:0]  r_tmo_cnt;
    logic                r_err;

    logic                w_accept_hs;
    logic [1:0]          w_fwd_sel;
    logic                w_takes_redirect;
    logic [XLEN-1:0]     w_target;
    logic                w_commit;
    logic                w_link_cls;
    logic [XLEN-1:0]     w_pc_nxt;
    logic                w_pc_load;
    logic                w_fault;

    cu_hazard_detect u_hazard_detect (
        .rs1     (rs1),
        .rs2     (rs2),
        .last_rd (r_last_rd),
        .fwd_sel (w_fwd_sel)
    );

    // Gating with reset keeps the IDU from handing over an instruction
    // that the sequencer would drop while being reset.
    assign cu_accept   = (r_state == IDLE) && !reset;
    assign w_accept_hs = IDU_ready && cu_accept;

    assign w_link_cls       = (r_cls == JAL) || (r_cls == JALR);
    assign w_takes_redirect = w_link_cls || ((r_cls == BRANCH) && branch_taken);
    // JALR targets are halfword-aligned by clearing bit 0.
    assign w_target         = (r_cls == JALR) ? {r_result[XLEN-1:1], 1'b0} : r_result;

    // A fault seen in the commit cycle pre-empts the commit itself.
    assign w_commit = ((r_state == WB) || (r_state == JSTALL)) && !alu_err;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pc_load   = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept_hs) begin
                    w_state_nxt = (instr_class == SYSTEM) ? HALT : ISSUE;
                end
            end
            ISSUE: begin
                if (alu_err) begin
                    w_state_nxt = HALT;
                    w_fault     = 1'b1;
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                // Fault beats a simultaneous result; a result on the timeout
                // cycle itself is still accepted.
                if (alu_err) begin
                    w_state_nxt = HALT;
                    w_fault     = 1'b1;
                end else if (alu_done) begin
                    w_state_nxt = w_takes_redirect ? JSTALL : WB;
                end else if (r_tmo_cnt == c_tmo_max) begin
                    w_state_nxt = HALT;
                    w_fault     = 1'b1;
                end
            end
            WB, JSTALL: begin
                if (alu_err) begin
                    w_state_nxt = HALT;
                    w_fault     = 1'b1;
                end else begin
                    w_pc_load = 1'b1;
                    w_pc_nxt  = (r_state == WB) ? (r_pc + c_pc_step) : w_target;
                    // The overrun is reported together with the offending PC.
                    if (w_pc_nxt >= c_pc_limit) begin
                        w_state_nxt = HALT;
                        w_fault     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cls     <= ALU;
            r_op      <= 5'd0;
            r_rd      <= 5'd0;
            r_last_rd <= 5'd0;
            r_fwd_sel <= FWD_NONE;
            r_result  <= '0;
            r_pc      <= '0;
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept_hs) begin
                r_cls     <= instr_class;
                r_op      <= alu_op_in;
                r_rd      <= rd;
                r_fwd_sel <= w_fwd_sel;
            end

            if ((r_state == EXEC) && alu_done) begin
                r_result <= alu_result;
            end

            // Counts EXEC cycles since alu_start; zero outside EXEC.
            if (r_state == EXEC) begin
                r_tmo_cnt <= r_tmo_cnt + c_cnt_w'(1);
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_pc_load) begin
                r_pc <= w_pc_nxt;
            end

            // A redirect invalidates the forwarding source.
            if (w_commit) begin
                r_last_rd <= (r_state == JSTALL) ? 5'd0 : r_rd;
            end

            if (w_fault) begin
                r_err <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    always_comb begin
        alu_op_out  = 5'd0;
        alu_start   = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = '0;
        pc_redirect = 1'b0;
        pc_target   = '0;

        if ((r_state == ISSUE) || (r_state == EXEC)) begin
            alu_op_out = r_op;
        end
        if ((r_state == EXEC) && (r_tmo_cnt == '0)) begin
            alu_start = 1'b1;
        end

        if (w_commit && (r_rd != 5'd0)) begin
            if ((r_state == WB) && class_writes_rd(r_cls)) begin
                wb_en   = 1'b1;
                wb_addr = r_rd;
                wb_data = r_result;
            end else if ((r_state == JSTALL) && w_link_cls) begin
                wb_en   = 1'b1;
                wb_addr = r_rd;
                wb_data = r_pc + c_pc_step;
            end
        end

        if (w_commit && (r_state == JSTALL)) begin
            pc_redirect = 1'b1;
            pc_target   = w_target;
        end
    end

    assign fwd_sel = r_fwd_sel;
    assign cu_pc   = r_pc;
    assign halt    = (r_state == HALT);
    assign err     = r_err;

    //--------------------------------------------------------------------------
    // Performance counters
    //--------------------------------------------------------------------------
`ifdef CU_SEQ_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_stall;
    logic        w_stall_cycle;

    assign w_stall_cycle = (r_state == ISSUE) || (r_state == EXEC) || (r_state == JSTALL);

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_commit && (r_perf_retired != '1)) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
            if (w_stall_cycle && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`else
    assign perf_retired = 32'd0;
    assign perf_stall   = 32'd0;
`endif

endmodule : cu_issue_sequencer
`default_nettype wire

// File: tb/tb_cu_issue_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_cu_issue_sequencer                                        |
// | Description : Scoreboard bench for cu_issue_sequencer. The driver pushes   |
// |               expected ALU issues, register writes and redirects derived  |
// |               from an architectural PC/last_rd model; a monitor pops and  |
// |               compares whenever the DUT presents them.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cu_issue_sequencer;
    import cu_pkg::*;

    localparam int unsigned XLEN = 32;

    logic              soc_clk = 1'b0;
    logic              reset = 1'b1;
    logic              IDU_ready = 1'b0;
    logic              cu_accept;
    instr_class_e      instr_class = ALU;
    logic [4:0]        alu_op_in = '0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic [4:0]        rs2 = '0;
    logic [4:0]        alu_op_out;
    logic              alu_start;
    logic              alu_done = 1'b0;
    logic [XLEN-1:0]   alu_result = '0;
    logic              branch_taken = 1'b0;
    logic              alu_err = 1'b0;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic [1:0]        fwd_sel;
    logic              pc_redirect;
    logic [XLEN-1:0]   pc_target;
    logic [XLEN-1:0]   cu_pc;
    logic              halt;
    logic              err;
    logic [31:0]       perf_retired;
    logic [31:0]       perf_stall;

    cu_issue_sequencer #(.XLEN(XLEN), .ALU_TIMEOUT(8), .PC_LIMIT(512)) dut (
        .soc_clk(soc_clk), .reset(reset), .IDU_ready(IDU_ready), .cu_accept(cu_accept),
        .instr_class(instr_class), .alu_op_in(alu_op_in), .rd(rd), .rs1(rs1), .rs2(rs2),
        .alu_op_out(alu_op_out), .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .branch_taken(branch_taken), .alu_err(alu_err),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .fwd_sel(fwd_sel),
        .pc_redirect(pc_redirect), .pc_target(pc_target), .cu_pc(cu_pc),
        .halt(halt), .err(err), .perf_retired(perf_retired), .perf_stall(perf_stall)
    );

    always #5 soc_clk = ~soc_clk;

    int cyc = 0;
    always @(posedge soc_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [4:0] op; logic [1:0] fwd; } iss_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } wb_t;
    iss_t        iss_q[$];
    wb_t         wb_q[$];
    logic [31:0] redir_q[$];

    // Architectural model state.
    logic [31:0] m_pc;
    logic [4:0]  m_last_rd;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_event(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    //--------------------------------------------------------------------------
    // Monitor
    //--------------------------------------------------------------------------
    initial begin
        iss_t e_iss;
        wb_t  e_wb;
        logic [31:0] e_tgt;
        forever begin
            @(negedge soc_clk);
            if (!reset) begin
                if (alu_start) begin
                    if (iss_q.size() == 0) fail_event("unexpected alu_start");
                    else begin
                        e_iss = iss_q.pop_front();
                        chk("alu_op_out", {27'd0, alu_op_out}, {27'd0, e_iss.op});
                        chk("fwd_sel", {30'd0, fwd_sel}, {30'd0, e_iss.fwd});
                    end
                end
                if (wb_en) begin
                    if (wb_q.size() == 0) fail_event("unexpected wb_en");
                    else begin
                        e_wb = wb_q.pop_front();
                        chk("wb_addr", {27'd0, wb_addr}, {27'd0, e_wb.addr});
                        chk("wb_data", wb_data, e_wb.data);
                    end
                end
                if (pc_redirect) begin
                    if (redir_q.size() == 0) fail_event("unexpected pc_redirect");
                    else begin
                        e_tgt = redir_q.pop_front();
                        chk("pc_target", pc_target, e_tgt);
                    end
                    chk("cu_accept during stall", {31'd0, cu_accept}, 32'd0);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Reset with drain checks and reset-state checks
    //--------------------------------------------------------------------------
    task automatic do_reset();
        @(posedge soc_clk); #1;
        reset = 1'b1; IDU_ready = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
        @(posedge soc_clk);
        @(negedge soc_clk);
        chk("cu_accept in reset", {31'd0, cu_accept}, 32'd0);
        chk("wb_q drained", wb_q.size(), 32'd0);
        chk("redir_q drained", redir_q.size(), 32'd0);
        wb_q.delete(); redir_q.delete(); iss_q.delete();
        @(posedge soc_clk); #1;
        reset = 1'b0;
        m_pc = 32'd0; m_last_rd = 5'd0;
        @(negedge soc_clk);
        chk("reset cu_pc", cu_pc, 32'd0);
        chk("reset halt", {31'd0, halt}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset wb_en", {31'd0, wb_en}, 32'd0);
        chk("reset pc_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("reset alu_start", {31'd0, alu_start}, 32'd0);
        chk("reset fwd_sel", {30'd0, fwd_sel}, 32'd0);
        chk("reset cu_accept", {31'd0, cu_accept}, 32'd1);
    endtask

    //--------------------------------------------------------------------------
    // One instruction. mode: 0 normal, 1 withhold alu_done, 2 alu_err with
    // alu_done, 3 reset after alu_start. SYSTEM ignores mode.
    //--------------------------------------------------------------------------
    task automatic run_instr(input instr_class_e cls, input logic [4:0] op, input logic [4:0] rdv,
                             input logic [4:0] rs1v, input logic [4:0] rs2v, input logic [31:0] res,
                             input logic tk, input int dly, input int mode);
        iss_t        ie;
        wb_t         we;
        logic [31:0] tgt;
        int          t;
        int          hs_cyc;

        ie.op     = op;
        ie.fwd[0] = (rs1v == m_last_rd) && (m_last_rd != 5'd0);
        ie.fwd[1] = (rs2v == m_last_rd) && (m_last_rd != 5'd0);
        if (cls != SYSTEM) iss_q.push_back(ie);

        if (mode == 0 && cls != SYSTEM) begin
            if (cls == JAL || cls == JALR || (cls == BRANCH && tk)) begin
                tgt = (cls == JALR) ? (res & ~32'h1) : res;
                if (cls != BRANCH && rdv != 5'd0) begin
                    we.addr = rdv; we.data = m_pc + 32'd4; wb_q.push_back(we);
                end
                redir_q.push_back(tgt);
                m_pc = tgt;
                m_last_rd = 5'd0;
            end else begin
                if ((cls == ALU || cls == LOAD) && rdv != 5'd0) begin
                    we.addr = rdv; we.data = res; wb_q.push_back(we);
                end
                m_pc = m_pc + 32'd4;
                m_last_rd = rdv;
            end
        end

        @(posedge soc_clk); #1;
        IDU_ready = 1'b1; instr_class = cls; alu_op_in = op; rd = rdv; rs1 = rs1v; rs2 = rs2v;
        t = 0;
        @(negedge soc_clk);
        while (!cu_accept && t < 20) begin @(negedge soc_clk); t++; end
        if (!cu_accept) begin fail_event("handshake timeout"); IDU_ready = 1'b0; return; end
        hs_cyc = cyc;
        @(posedge soc_clk); #1;
        IDU_ready = 1'b0;

        if (cls == SYSTEM) begin
            @(negedge soc_clk);
            chk("system halt", {31'd0, halt}, 32'd1);
            chk("system err", {31'd0, err}, 32'd0);
            IDU_ready = 1'b1;
            @(negedge soc_clk);
            chk("halted cu_accept", {31'd0, cu_accept}, 32'd0);
            IDU_ready = 1'b0;
            return;
        end

        t = 0;
        @(negedge soc_clk);
        while (!alu_start && t < 10) begin @(negedge soc_clk); t++; end
        if (!alu_start) begin fail_event("alu_start timeout"); return; end
        chk("start latency", cyc - hs_cyc, 32'd2);

        if (mode == 1) begin
            t = 0;
            while (!halt && t < 20) begin @(negedge soc_clk); t++; end
            chk("timeout halt", {31'd0, halt}, 32'd1);
            chk("timeout err", {31'd0, err}, 32'd1);
            chk("timeout cu_accept", {31'd0, cu_accept}, 32'd0);
            return;
        end
        if (mode == 3) begin
            #1 reset = 1'b1;
            @(posedge soc_clk); #1;
            reset = 1'b0;
            m_pc = 32'd0; m_last_rd = 5'd0;
            @(negedge soc_clk);
            chk("midexec reset cu_accept", {31'd0, cu_accept}, 32'd1);
            chk("midexec reset cu_pc", cu_pc, 32'd0);
            chk("midexec reset halt", {31'd0, halt}, 32'd0);
            repeat (10) @(negedge soc_clk);
            return;
        end

        repeat (dly) @(negedge soc_clk);
        #1;
        alu_done = 1'b1; alu_result = res; branch_taken = tk; alu_err = (mode == 2);
        @(posedge soc_clk); #1;
        alu_done = 1'b0; alu_err = 1'b0; branch_taken = 1'b0; alu_result = $urandom;

        if (mode == 2) begin
            @(negedge soc_clk);
            chk("errdone halt", {31'd0, halt}, 32'd1);
            chk("errdone err", {31'd0, err}, 32'd1);
            chk("errdone wb_en", {31'd0, wb_en}, 32'd0);
            repeat (3) @(negedge soc_clk);
            return;
        end

        t = 0;
        @(negedge soc_clk);
        while (!cu_accept && !halt && t < 10) begin @(negedge soc_clk); t++; end
        chk("turnaround", cyc - hs_cyc, 32'(4 + dly));
        chk("cu_pc", cu_pc, m_pc);
        if (m_pc >= 32'd512) begin
            chk("overrun halt", {31'd0, halt}, 32'd1);
            chk("overrun err", {31'd0, err}, 32'd1);
            chk("overrun cu_accept", {31'd0, cu_accept}, 32'd0);
        end else begin
            chk("running halt", {31'd0, halt}, 32'd0);
        end
    endtask

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        instr_class_e c;
        logic [4:0]   rdv;
        logic [31:0]  res;

        m_pc = 32'd0; m_last_rd = 5'd0;
        do_reset();

        // Directed sequence.
        run_instr(ALU,    5'd1, 5'd5, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b0, 2, 0);
        run_instr(ALU,    5'd2, 5'd6, 5'd5, 5'd5, 32'h0000_1234, 1'b0, 1, 0);
        run_instr(JAL,    5'd3, 5'd1, 5'd0, 5'd0, 32'h0000_0040, 1'b0, 0, 0);
        run_instr(ALU,    5'd4, 5'd0, 5'd0, 5'd3, 32'h0000_0055, 1'b0, 0, 0);
        run_instr(JALR,   5'd5, 5'd2, 5'd0, 5'd0, 32'h0000_0021, 1'b0, 3, 0);
        run_instr(BRANCH, 5'd6, 5'd0, 5'd2, 5'd3, 32'h0000_0100, 1'b0, 3, 0);
        run_instr(BRANCH, 5'd6, 5'd0, 5'd0, 5'd0, 32'h0000_0080, 1'b1, 1, 0);

        // Randomized stream kept below the PC limit.
        for (int i = 0; i < 60; i++) begin
            c   = instr_class_e'($urandom_range(0, 5));
            rdv = 5'($urandom_range(0, 7));
            if (m_pc >= 32'd480) c = JAL;
            if (c == STORE || c == BRANCH) rdv = 5'd0;
            if (c == JAL || c == JALR || c == BRANCH) begin
                res = 32'(4 * $urandom_range(0, 110));
                if (m_pc >= 32'd480) res = 32'(4 * $urandom_range(0, 20));
                if (c == JALR) res = res | 32'($urandom_range(0, 1));
            end else begin
                res = $urandom;
            end
            run_instr(c, 5'($urandom), rdv, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      res, 1'($urandom), $urandom_range(0, 7), 0);
        end

        // Halting scenarios.
        do_reset();
        run_instr(SYSTEM, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 0, 0);
        do_reset();
        run_instr(ALU, 5'd7, 5'd4, 5'd0, 5'd0, 32'h1, 1'b0, 0, 1);
        do_reset();
        run_instr(ALU, 5'd8, 5'd3, 5'd0, 5'd0, 32'h2, 1'b0, 1, 2);
        do_reset();
        run_instr(ALU, 5'd9, 5'd7, 5'd0, 5'd0, 32'h3, 1'b0, 0, 3);
        run_instr(JAL, 5'd3, 5'd0, 5'd0, 5'd0, 32'd508, 1'b0, 0, 0);
        run_instr(ALU, 5'd1, 5'd9, 5'd0, 5'd0, 32'hCAFE_F00D, 1'b0, 1, 0);

        repeat (3) @(negedge soc_clk);
        chk("perf_retired", perf_retired, 32'd0);
        chk("perf_stall", perf_stall, 32'd0);
        chk("final wb_q empty", wb_q.size(), 32'd0);
        chk("final redir_q empty", redir_q.size(), 32'd0);
        chk("final iss_q empty", iss_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_cu_issue_sequencer
`default_nettype wire
